// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared constants, FSM encoding and round-robin pick helper
package reg_write_arbiter_pkg;
   localparam int NUM_REQ = 4;
   localparam int IDX_W = 2;
   localparam int CNT_W = 16;
   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] win;
      logic found;
      win = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + IDX_W'(k);
         if (!found && req[idx]) begin
            win = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction
endpackage

// File: rtl/reg_write_arbiter_register.sv
// register: shared storage register with write enable and synchronous reset
module register #(
   parameter int BIT_WIDTH = 32,
   parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en_write,
   input  logic [BIT_WIDTH-1:0] data_in,
   output logic [BIT_WIDTH-1:0] data_out
);
   // load on enable, reset wins
   always_ff @(posedge clk)
      data_out <= reset ? RESET_VALUE : (en_write ? data_in : data_out);
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbitration of four writers onto one shared register
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*BIT_WIDTH-1:0] data_in,
   output logic [NUM_REQ-1:0]           ack,
   output logic [BIT_WIDTH-1:0]         data_out,
   output logic [IDX_W-1:0]             owner,
   output logic                         busy,
   output logic [CNT_W-1:0]             write_count
);
   state_t state, next_state;
   logic [IDX_W-1:0] rr_ptr, winner;
   logic en_write;
   logic [BIT_WIDTH-1:0] win_data;

   assign winner = rr_pick(req, rr_ptr);
   assign win_data = data_in[int'(winner)*BIT_WIDTH +: BIT_WIDTH];

   // state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : next_state;

   // a grant always lasts exactly one ACK cycle
   always_comb
      next_state = (state == IDLE && |req) ? ACK : IDLE;

   // ack follows the registered owner so it is one-hot at the winner during ACK
   always_comb begin
      en_write = (state == IDLE) && |req;
      busy = (state == ACK);
      ack = (state == ACK) ? NUM_REQ'(1) << owner : '0;
   end

   // pointer, owner and saturating count advance only when a write is captured
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         owner <= '0;
         write_count <= '0;
      end else if (en_write) begin
         rr_ptr <= winner + IDX_W'(1);
         owner <= winner;
         write_count <= (write_count == '1) ? write_count : write_count + CNT_W'(1);
      end
   end

   register #(
      .BIT_WIDTH(BIT_WIDTH),
      .RESET_VALUE(RESET_VALUE)
   ) u_reg (
      .clk(clk),
      .reset(reset),
      .en_write(en_write),
      .data_in(win_data),
      .data_out(data_out)
   );
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: table-driven check of arbitration, handshake, reset and saturation
module tb_reg_write_arbiter;
   import reg_write_arbiter_pkg::*;
   localparam int BW = 8;

   typedef struct {
      logic          rst;
      logic [3:0]    req;
      logic [4*BW-1:0] lanes;
      logic [3:0]    ack;
      logic [BW-1:0] data;
      logic [1:0]    own;
      logic          busy;
      logic [15:0]   cnt;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NUM_REQ-1:0] req = '0;
   logic [NUM_REQ*BW-1:0] data_in = '0;
   logic [NUM_REQ-1:0] ack;
   logic [BW-1:0] data_out;
   logic [IDX_W-1:0] owner;
   logic busy;
   logic [CNT_W-1:0] write_count;
   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[$];
   vec_t sat[$];

   reg_write_arbiter #(.BIT_WIDTH(BW), .RESET_VALUE('0)) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .data_in(data_in),
      .ack(ack),
      .data_out(data_out),
      .owner(owner),
      .busy(busy),
      .write_count(write_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [31:0] l, input logic [3:0] a,
                               input logic [7:0] d, input logic [1:0] o, input logic b, input logic [15:0] c);
      vec_t v;
      v.rst = r; v.req = q; v.lanes = l; v.ack = a; v.data = d; v.own = o; v.busy = b; v.cnt = c;
      return v;
   endfunction

   task automatic apply(input string tag, input int idx, input vec_t v);
      @(negedge clk);
      reset = v.rst;
      req = v.req;
      data_in = v.lanes;
      @(posedge clk);
      #1;
      n_vec++;
      if (ack !== v.ack || data_out !== v.data || owner !== v.own || busy !== v.busy || write_count !== v.cnt) begin
         n_err++;
         $display("FAIL %s[%0d]: got ack=%b data=%h owner=%0d busy=%b cnt=%h, want ack=%b data=%h owner=%0d busy=%b cnt=%h",
                  tag, idx, ack, data_out, owner, busy, write_count, v.ack, v.data, v.own, v.busy, v.cnt);
      end
   endtask

   initial begin
      vecs.push_back(mk(1, 4'b0000, 32'h00000000, 4'b0000, 8'h00, 0, 0, 16'd0));
      vecs.push_back(mk(1, 4'b1111, 32'hFFFFFFFF, 4'b0000, 8'h00, 0, 0, 16'd0));
      vecs.push_back(mk(0, 4'b0100, 32'h00090000, 4'b0100, 8'h09, 2, 1, 16'd1));
      vecs.push_back(mk(0, 4'b0000, 32'h00090000, 4'b0000, 8'h09, 2, 0, 16'd1));
      vecs.push_back(mk(0, 4'b0000, 32'h00090000, 4'b0000, 8'h09, 2, 0, 16'd1));
      vecs.push_back(mk(1, 4'b0000, 32'h00000000, 4'b0000, 8'h00, 0, 0, 16'd0));
      vecs.push_back(mk(0, 4'b1111, 32'h04030201, 4'b0001, 8'h01, 0, 1, 16'd1));
      vecs.push_back(mk(0, 4'b1110, 32'h04030201, 4'b0000, 8'h01, 0, 0, 16'd1));
      vecs.push_back(mk(0, 4'b1110, 32'h04030201, 4'b0010, 8'h02, 1, 1, 16'd2));
      vecs.push_back(mk(0, 4'b1100, 32'h04030201, 4'b0000, 8'h02, 1, 0, 16'd2));
      vecs.push_back(mk(0, 4'b1100, 32'h04030201, 4'b0100, 8'h03, 2, 1, 16'd3));
      vecs.push_back(mk(0, 4'b1000, 32'h04030201, 4'b0000, 8'h03, 2, 0, 16'd3));
      vecs.push_back(mk(0, 4'b1000, 32'h04030201, 4'b1000, 8'h04, 3, 1, 16'd4));
      vecs.push_back(mk(0, 4'b0000, 32'h04030201, 4'b0000, 8'h04, 3, 0, 16'd4));
      vecs.push_back(mk(0, 4'b0001, 32'h06000005, 4'b0001, 8'h05, 0, 1, 16'd5));
      vecs.push_back(mk(0, 4'b0000, 32'h06000005, 4'b0000, 8'h05, 0, 0, 16'd5));
      vecs.push_back(mk(0, 4'b1001, 32'h06000005, 4'b1000, 8'h06, 3, 1, 16'd6));
      vecs.push_back(mk(0, 4'b0001, 32'h06000005, 4'b0000, 8'h06, 3, 0, 16'd6));
      vecs.push_back(mk(0, 4'b0001, 32'h06000005, 4'b0001, 8'h05, 0, 1, 16'd7));
      vecs.push_back(mk(0, 4'b0000, 32'h06000005, 4'b0000, 8'h05, 0, 0, 16'd7));
      vecs.push_back(mk(0, 4'b0010, 32'hBBCC07AA, 4'b0010, 8'h07, 1, 1, 16'd8));
      vecs.push_back(mk(1, 4'b0000, 32'hBBCC07AA, 4'b0000, 8'h00, 0, 0, 16'd0));
      vecs.push_back(mk(0, 4'b0000, 32'hBBCC07AA, 4'b0000, 8'h00, 0, 0, 16'd0));
      vecs.push_back(mk(0, 4'b0100, 32'h00110000, 4'b0100, 8'h11, 2, 1, 16'd1));
      vecs.push_back(mk(0, 4'b0000, 32'h00220000, 4'b0000, 8'h11, 2, 0, 16'd1));
      vecs.push_back(mk(0, 4'b0000, 32'h00330000, 4'b0000, 8'h11, 2, 0, 16'd1));
      vecs.push_back(mk(0, 4'b0011, 32'h00005544, 4'b0001, 8'h44, 0, 1, 16'd2));
      vecs.push_back(mk(0, 4'b0010, 32'h00005544, 4'b0000, 8'h44, 0, 0, 16'd2));
      vecs.push_back(mk(0, 4'b0010, 32'h00005544, 4'b0010, 8'h55, 1, 1, 16'd3));
      vecs.push_back(mk(0, 4'b0000, 32'h00005544, 4'b0000, 8'h55, 1, 0, 16'd3));
      vecs.push_back(mk(0, 4'b0100, 32'h00660000, 4'b0100, 8'h66, 2, 1, 16'd4));
      vecs.push_back(mk(0, 4'b0100, 32'h00660000, 4'b0000, 8'h66, 2, 0, 16'd4));
      vecs.push_back(mk(0, 4'b0100, 32'h00660000, 4'b0100, 8'h66, 2, 1, 16'd5));
      vecs.push_back(mk(0, 4'b0000, 32'h00660000, 4'b0000, 8'h66, 2, 0, 16'd5));
      sat.push_back(mk(0, 4'b0001, 32'h00000001, 4'b0001, 8'h01, 0, 1, 16'hFFFE));
      sat.push_back(mk(0, 4'b0000, 32'h00000001, 4'b0000, 8'h01, 0, 0, 16'hFFFE));
      sat.push_back(mk(0, 4'b0001, 32'h00000001, 4'b0001, 8'h01, 0, 1, 16'hFFFF));
      sat.push_back(mk(0, 4'b0000, 32'h00000001, 4'b0000, 8'h01, 0, 0, 16'hFFFF));
      sat.push_back(mk(0, 4'b0001, 32'h00000008, 4'b0001, 8'h08, 0, 1, 16'hFFFF));
      sat.push_back(mk(0, 4'b0000, 32'h00000008, 4'b0000, 8'h08, 0, 0, 16'hFFFF));
      foreach (vecs[i]) apply("vec", i, vecs[i]);
      @(negedge clk);
      force dut.write_count = 16'hFFFD;
      #1;
      release dut.write_count;
      foreach (sat[i]) apply("sat", i, sat[i]);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 32, width of the shared register and of each requester data lane.
REQ-002 Parameter RESET_VALUE, default 0, value loaded into the shared register on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 req  input  4  per-requester write request; bit i belongs to requester i.
REQ-006 data_in  input  4*BIT_WIDTH  requester i data on bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-007 ack  output  4  one-hot single-cycle acknowledge to the requester whose write completed.
REQ-008 data_out  output  BIT_WIDTH  current contents of the shared register.
REQ-009 owner  output  2  index of the requester that performed the last completed write.
REQ-010 busy  output  1  high while the FSM is in ACK.
REQ-011 write_count  output  16  number of completed writes since reset, saturating.

Function
REQ-012 FSM shall have two states: IDLE and ACK.
REQ-013 In IDLE with req != 0, the winner shall be the first set req bit at or after rr_ptr, searching upward modulo 4.
- Register en_write asserted combinationally in the same cycle.
- Winner's data lane captured at that rising edge.
- FSM moves to ACK.
REQ-014 In IDLE with req == 0: en_write low; state, rr_ptr, owner and write_count unchanged.
REQ-015 In ACK, ack shall be one-hot at the winner index for exactly one cycle, then the FSM returns to IDLE.
- req is ignored in ACK.
- en_write is low in ACK.
REQ-016 Latency: req sampled high in cycle c -> data_out updated and ack high in cycle c+1.
- Maximum throughput: one write per two cycles.
REQ-017 On the IDLE->ACK edge:
- rr_ptr becomes (winner+1) mod 4.
- owner becomes winner.
- write_count increments, holding at 16'hFFFF once reached.
REQ-018 Requester handshake: hold req and data stable until ack is seen; deassert req on the edge following ack; a req still high in the cycle after ACK is treated as a new request.
REQ-019 Simultaneous requests shall be served strictly round-robin; no requester waits more than 3 grants while continuously requesting.
REQ-020 Changes to data_in of a requester not currently winning shall have no effect on data_out.

Reset
REQ-021 When reset is high at a rising edge, the following values shall be loaded regardless of state, including mid-ACK:
- state=IDLE, rr_ptr=0, owner=0, write_count=0.
- ack=0, busy=0, data_out=RESET_VALUE.
REQ-022 A write whose capture edge coincides with reset shall be discarded; reset has priority.
REQ-023 An ack pending when reset is asserted shall be dropped and not reissued.

Structure
REQ-024 State encodings (IDLE=0, ACK=1) and NUM_REQ=4 shall live in the shared constants header included by the arbiter and its bench.
REQ-025 The shared storage shall be one instance of the existing Register module, with:
- BIT_WIDTH and RESET_VALUE passed through.
- en_write driven by the arbiter.
- data_in driven by the winner mux.
- reset tied to reset.
REQ-026 The arbiter shall contain no other storage for the data value; data_out is the Register output.

Verification
REQ-027 Reset at time 0 -> data_out=0, ack=0, owner=0, write_count=0, busy=0.
REQ-028 Single request: req=4'b0100, lane2=9 in cycle c -> cycle c+1 data_out=9, ack=4'b0100, owner=2, busy=1; cycle c+2 ack=0, busy=0, write_count=1.
REQ-029 All four requesting continuously, lanes=1,2,3,4, each drops req after its ack -> grants in order 0,1,2,3; data_out sequence 1,2,3,4 at 2-cycle spacing; write_count=4.
REQ-030 Fairness: rr_ptr=1, req=4'b1001 -> requester 3 granted first, then requester 0.
REQ-031 Reset mid-ACK after requester 1 writes 7 -> next cycle data_out=0, ack=0, state IDLE; the ack is not reissued.
REQ-032 Saturation: force 65536 completed writes -> write_count holds at 16'hFFFF; data_out still tracks the last written value, e.g. 8.
